// File: rtl/soc_axi_initiator.sv
// Single-outstanding AXI4 initiator: one command becomes one single-beat read or write burst,
// with a bounded wait on the R/B response.
module soc_axi_initiator #(
  parameter int TAGW    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic            aclk,
  input  logic            rstn,
  // command / response side
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [31:0]     cmd_addr,
  input  logic [31:0]     cmd_wdata,
  input  logic [3:0]      cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_timeout,
  // AR channel
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [TAGW-1:0] arid,
  output logic [7:0]      arlen,
  output logic [1:0]      arburst,
  output logic [2:0]      arsize,
  // R channel
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic [TAGW-1:0] rid,
  input  logic            rlast,
  // AW channel
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     awaddr,
  output logic [TAGW-1:0] awid,
  output logic [7:0]      awlen,
  output logic [1:0]      awburst,
  output logic [2:0]      awsize,
  // W channel
  output logic            wvalid,
  input  logic            wready,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  // B channel
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  input  logic [TAGW-1:0] bid,
  // debug
  output logic [2:0]      dbg_state_o
);

  // Handshakes: a transfer happens on any rising aclk where VALID and READY are both high;
  // VALID is never withdrawn before its handshake and its payload is held stable meanwhile.

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ADDR  = 3'd1,
    S_RD_DATA  = 3'd2,
    S_WR_REQ   = 3'd3,
    S_WR_BRESP = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [TAGW-1:0] id_q;
  logic [TAGW-1:0] txn_id_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            aw_done_q;
  logic            w_done_q;
  logic [31:0]     rsp_rdata_q;
  logic [1:0]      rsp_resp_q;
  logic            rsp_timeout_q;

  logic r_match, b_match, tmo_hit, aw_fin, w_fin;
  logic unused_inputs;

  assign unused_inputs = ^{rlast, cmd_addr[1:0]};

  assign r_match = rvalid && (rid == id_q);
  assign b_match = bvalid && (bid == id_q);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
  // awvalid/wvalid are high exactly while the matching done flag is low
  assign aw_fin  = aw_done_q || awready;
  assign w_fin   = w_done_q || wready;

  always_ff @(posedge aclk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cmd_valid)           state_d = cmd_write ? S_WR_REQ : S_RD_ADDR;
      S_RD_ADDR:  if (arready)             state_d = S_RD_DATA;
      S_RD_DATA:  if (r_match || tmo_hit)  state_d = S_RESP;
      S_WR_REQ:   if (aw_fin && w_fin)     state_d = S_WR_BRESP;
      S_WR_BRESP: if (b_match || tmo_hit)  state_d = S_RESP;
      S_RESP:     if (rsp_ready)           state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE) && rstn;
    arvalid     = (state_q == S_RD_ADDR);
    rready      = (state_q == S_IDLE) || (state_q == S_RD_DATA);
    awvalid     = (state_q == S_WR_REQ) && !aw_done_q;
    wvalid      = (state_q == S_WR_REQ) && !w_done_q;
    bready      = (state_q == S_IDLE) || (state_q == S_WR_BRESP);
    rsp_valid   = (state_q == S_RESP);
    dbg_state_o = state_q;
  end

  always_ff @(posedge aclk) begin
    if (!rstn) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      id_q          <= '0;
      txn_id_q      <= '0;
      tmo_cnt_q     <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q        <= {cmd_addr[31:2], 2'b00};
            wdata_q       <= cmd_wdata;
            wstrb_q       <= cmd_wstrb;
            id_q          <= txn_id_q;
            txn_id_q      <= txn_id_q + TAGW'(1);
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
          end
        end
        S_RD_DATA: begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
          if (r_match) begin
            rsp_rdata_q <= rdata;
            rsp_resp_q  <= rresp;
          end else if (tmo_hit) begin
            rsp_resp_q    <= 2'b10;
            rsp_timeout_q <= 1'b1;
          end
        end
        S_WR_REQ: begin
          if (awready) aw_done_q <= 1'b1;
          if (wready)  w_done_q  <= 1'b1;
        end
        S_WR_BRESP: begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
          if (b_match) begin
            rsp_resp_q <= bresp;
          end else if (tmo_hit) begin
            rsp_resp_q    <= 2'b10;
            rsp_timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign araddr      = addr_q;
  assign arid        = id_q;
  assign arlen       = 8'd0;
  assign arburst     = 2'b01;
  assign arsize      = 3'b010;
  assign awaddr      = addr_q;
  assign awid        = id_q;
  assign awlen       = 8'd0;
  assign awburst     = 2'b01;
  assign awsize      = 3'b010;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wlast       = 1'b1;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_soc_axi_initiator.sv
// Directed bench for soc_axi_initiator (TAGW=2, TIMEOUT=8): inputs driven and outputs
// sampled on the falling edge, responder behaviour scripted per test.
module tb_soc_axi_initiator;

  localparam int TAGW    = 2;
  localparam int TIMEOUT = 8;

  logic            aclk = 1'b0;
  logic            rstn;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [31:0]     cmd_addr, cmd_wdata;
  logic [3:0]      cmd_wstrb;
  logic            rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0]     rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            arvalid, arready;
  logic [31:0]     araddr;
  logic [TAGW-1:0] arid;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic [2:0]      arsize;
  logic            rvalid, rready, rlast;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic [TAGW-1:0] rid;
  logic            awvalid, awready;
  logic [31:0]     awaddr;
  logic [TAGW-1:0] awid;
  logic [7:0]      awlen;
  logic [1:0]      awburst;
  logic [2:0]      awsize;
  logic            wvalid, wready, wlast;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [TAGW-1:0] bid;
  logic [2:0]      dbg_state_o;

  int n_chk = 0;
  int n_bad = 0;

  soc_axi_initiator #(.TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .aclk(aclk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // zero-wait read with bounded waits on arvalid and rsp_valid
  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input logic [TAGW-1:0] exp_id, input logic [31:0] exp_addr);
    int n;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!arvalid && n < 20) begin tick(); n++; end
    check_eq("rd_arvalid", arvalid, 1);
    check_eq("rd_arid", arid, exp_id);
    check_eq("rd_araddr", araddr, exp_addr);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rid = exp_id; rdata = data; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check_eq("rd_rsp_valid", rsp_valid, 1);
    check_eq("rd_rsp_rdata", rsp_rdata, data);
    release_rsp();
  endtask

  initial begin
    logic [31:0] exp_id_seq [5];
    rstn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;

    // reset state
    repeat (3) tick();
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_state", dbg_state_o, 0);
    rstn = 1'b1;
    tick();
    check_eq("idle_cmd_ready", cmd_ready, 1);

    // read 0x10, zero-wait, exact latency
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
    tick();
    cmd_valid = 0;
    check_eq("t1_arvalid_n1", arvalid, 1);
    check_eq("t1_araddr", araddr, 32'h10);
    check_eq("t1_arid", arid, 0);
    check_eq("t1_arlen", arlen, 0);
    check_eq("t1_arburst", arburst, 2'b01);
    check_eq("t1_arsize", arsize, 3'b010);
    arready = 1;
    tick();
    arready = 0;
    check_eq("t1_arvalid_n2", arvalid, 0);
    check_eq("t1_rready", rready, 1);
    check_eq("t1_rsp_valid_n2", rsp_valid, 0);
    rvalid = 1; rid = 0; rdata = 32'hA5A5_0001; rresp = 2'b00;
    tick();
    rvalid = 0;
    check_eq("t1_rsp_valid_n3", rsp_valid, 1);
    check_eq("t1_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    check_eq("t1_rsp_resp", rsp_resp, 0);
    check_eq("t1_rsp_timeout", rsp_timeout, 0);
    // response held while rsp_ready is low
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_rsp_valid", rsp_valid, 1);
      check_eq("hold_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      check_eq("hold_rsp_resp", rsp_resp, 0);
      check_eq("hold_cmd_ready", cmd_ready, 0);
    end
    release_rsp();
    check_eq("t1_rsp_done", rsp_valid, 0);
    check_eq("t1_back_idle", cmd_ready, 1);

    // write 0x4, awready delayed 3 cycles, wready=1
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'b0101;
    wready = 1;
    tick();
    cmd_valid = 0;
    check_eq("t2_awaddr", awaddr, 32'h4);
    check_eq("t2_awid", awid, 1);
    check_eq("t2_wdata", wdata, 32'hDEAD_BEEF);
    check_eq("t2_wstrb", wstrb, 4'b0101);
    check_eq("t2_wlast", wlast, 1);
    check_eq("t2_awlen", awlen, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_awvalid", awvalid, 1);
      check_eq("t2_wvalid", wvalid, (i == 0) ? 1 : 0);
      if (i == 3) awready = 1;
      tick();
    end
    awready = 0; wready = 0;
    check_eq("t2_awvalid_off", awvalid, 0);
    check_eq("t2_bready", bready, 1);
    bvalid = 1; bid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    check_eq("t2_rsp_valid", rsp_valid, 1);
    check_eq("t2_rsp_resp", rsp_resp, 0);
    check_eq("t2_rsp_rdata", rsp_rdata, 0);
    check_eq("t2_rsp_timeout", rsp_timeout, 0);
    release_rsp();

    // read timeout: no rvalid at all
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8;
    tick();
    cmd_valid = 0;
    check_eq("t3_arid", arid, 2);
    arready = 1;
    tick();
    arready = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      check_eq("t3_tmo_wait", rsp_valid, 0);
      tick();
    end
    check_eq("t3_rsp_valid", rsp_valid, 1);
    check_eq("t3_rsp_resp", rsp_resp, 2'b10);
    check_eq("t3_rsp_timeout", rsp_timeout, 1);
    check_eq("t3_rsp_rdata", rsp_rdata, 0);
    release_rsp();
    // late beat with the old rid is drained in IDLE
    check_eq("t3_idle_rready", rready, 1);
    rvalid = 1; rid = 2; rdata = 32'hFFFF_FFFF;
    tick();
    rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_no_late_rsp", rsp_valid, 0);
      check_eq("t3_state_idle", dbg_state_o, 0);
      tick();
    end

    // mismatched bid first, matching bid two cycles later
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC; cmd_wdata = 32'h11; cmd_wstrb = 4'hF;
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    check_eq("t4_awid", awid, 3);
    tick();
    awready = 0; wready = 0;
    check_eq("t4_aw_w_off", {awvalid, wvalid}, 0);
    bvalid = 1; bid = 0; bresp = 2'b11;
    tick();
    bvalid = 0;
    check_eq("t4_drop_b0", rsp_valid, 0);
    tick();
    check_eq("t4_drop_b1", rsp_valid, 0);
    bvalid = 1; bid = 3; bresp = 2'b01;
    tick();
    bvalid = 0;
    check_eq("t4_rsp_valid", rsp_valid, 1);
    check_eq("t4_rsp_resp", rsp_resp, 2'b01);
    check_eq("t4_rsp_timeout", rsp_timeout, 0);
    release_rsp();
    check_eq("t4_single_rsp", rsp_valid, 0);

    // matching beat on the last timeout cycle wins; id wrapped to 0
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    tick();
    cmd_valid = 0;
    check_eq("t5_arid_wrap", arid, 0);
    arready = 1;
    tick();
    arready = 0;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      check_eq("t5_wait", rsp_valid, 0);
      tick();
    end
    rvalid = 1; rid = 0; rdata = 32'h1234_5678; rresp = 2'b00;
    tick();
    rvalid = 0;
    check_eq("t5_rsp_valid", rsp_valid, 1);
    check_eq("t5_rsp_timeout", rsp_timeout, 0);
    check_eq("t5_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check_eq("t5_rsp_resp", rsp_resp, 0);
    release_rsp();

    // reset while in WR_REQ
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h55; cmd_wstrb = 4'h1;
    tick();
    cmd_valid = 0;
    check_eq("t6_in_wr_req", dbg_state_o, 3);
    check_eq("t6_awvalid_pre", awvalid, 1);
    rstn = 0;
    tick();
    rstn = 1;
    check_eq("t6_awvalid", awvalid, 0);
    check_eq("t6_wvalid", wvalid, 0);
    check_eq("t6_state", dbg_state_o, 0);

    // back-to-back reads: txn_id restarts at 0 and wraps after 3
    exp_id_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      do_read(32'h40 + 32'(i * 4) + ((i == 2) ? 32'h3 : 32'h0), 32'hC0DE_0000 + 32'(i),
              TAGW'(exp_id_seq[i]), 32'h40 + 32'(i * 4));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
